// File: rtl/fu_pkg.sv
// Shared definitions for the FU dispatch controllers: default widths and the
// controller FSM state encoding.
package fu_pkg;
  localparam int FU_DATA_WIDTH = 32;
  localparam int FU_TAG_WIDTH  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;
endpackage

// File: rtl/fu_dispatch_ctrl_if.sv
// Bundles the issue, FU and writeback sides of one dispatch controller.
// master = the controller, slave = everything around it.
interface fu_dispatch_ctrl_if import fu_pkg::*; #(
  parameter int DATA_WIDTH = FU_DATA_WIDTH,
  parameter int TAG_WIDTH  = FU_TAG_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_WIDTH-1:0] in_op0;
  logic [DATA_WIDTH-1:0] in_op1;
  logic                  fu_ce;
  logic [DATA_WIDTH-1:0] fu_data_0;
  logic [DATA_WIDTH-1:0] fu_data_1;
  logic                  fu_idle;
  logic                  fu_done;
  logic [DATA_WIDTH-1:0] fu_result;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic [DATA_WIDTH-1:0] wb_result;
  logic                  wb_error;
  logic                  busy;

  modport master (
    input  in_valid, in_tag, in_op0, in_op1, fu_idle, fu_done, fu_result, wb_ready,
    output in_ready, fu_ce, fu_data_0, fu_data_1, wb_valid, wb_tag, wb_result, wb_error, busy
  );

  modport slave (
    output in_valid, in_tag, in_op0, in_op1, fu_idle, fu_done, fu_result, wb_ready,
    input  in_ready, fu_ce, fu_data_0, fu_data_1, wb_valid, wb_tag, wb_result, wb_error, busy
  );
endinterface

// File: rtl/fu_watchdog.sv
// Saturating cycle counter that flags an FU which has been waited on for
// TIMEOUT cycles without completing.
module fu_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != {CW{1'b1}}))
      count <= count + 1'b1;
  end

  assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fu_dispatch_ctrl.sv
// Initiator side of the FU ce/idle/done protocol: accepts one op, strobes the FU,
// waits for done (or watchdog expiry) and presents the result to writeback.
module fu_dispatch_ctrl import fu_pkg::*; #(
  parameter int DATA_WIDTH = FU_DATA_WIDTH,
  parameter int TAG_WIDTH  = FU_TAG_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst,
  fu_dispatch_ctrl_if.master bus
);
  state_e                state, state_nxt;
  logic                  in_ready;
  logic                  accept;
  logic                  expired;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [DATA_WIDTH-1:0] op0_q, op1_q, result_q;
  logic                  error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // WB can hand straight over to ISSUE when a new op is waiting at the handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = bus.fu_idle;
        if (bus.in_valid && bus.fu_idle) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.fu_done || expired) state_nxt = S_WB;
      end
      S_WB: begin
        in_ready = bus.wb_ready && bus.fu_idle;
        if (bus.wb_ready) state_nxt = (bus.in_valid && bus.fu_idle) ? S_ISSUE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // Done takes priority over a coinciding watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q    <= '0;
      op0_q    <= '0;
      op1_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        tag_q <= bus.in_tag;
        op0_q <= bus.in_op0;
        op1_q <= bus.in_op1;
      end
      if (state == S_WAIT) begin
        if (bus.fu_done) begin
          result_q <= bus.fu_result;
          error_q  <= 1'b0;
        end else if (expired) begin
          result_q <= '0;
          error_q  <= 1'b1;
        end
      end
    end
  end

  fu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_ISSUE),
    .enable  (state == S_WAIT),
    .expired (expired)
  );

  assign bus.in_ready  = in_ready;
  assign bus.fu_ce     = (state == S_ISSUE);
  assign bus.fu_data_0 = op0_q;
  assign bus.fu_data_1 = op1_q;
  assign bus.wb_valid  = (state == S_WB);
  assign bus.wb_tag    = tag_q;
  assign bus.wb_result = result_q;
  assign bus.wb_error  = error_q;
  assign bus.busy      = (state != S_IDLE);
endmodule
